// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and hazard_ctrl:
// hazard observations flow in, latch/PC enables and flushes flow out.
interface hazard_ctrl_if;
  logic       ihit;
  logic       dhit;
  logic       dmem_req;
  logic       halt_mem;
  logic       branch_taken;
  logic       ex_is_load;
  logic [4:0] ex_wsel;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       pc_en;
  logic       redir_hold;
  logic       fd_en;
  logic       de_en;
  logic       em_en;
  logic       mw_en;
  logic       fd_flush;
  logic       de_flush;
  logic       em_flush;
  logic       mw_flush;
  logic       halted;

  modport master (
    output ihit, dhit, dmem_req, halt_mem, branch_taken, ex_is_load,
           ex_wsel, id_rs, id_rt, id_uses_rt,
    input  pc_en, redir_hold, fd_en, de_en, em_en, mw_en,
           fd_flush, de_flush, em_flush, mw_flush, halted
  );

  modport slave (
    input  ihit, dhit, dmem_req, halt_mem, branch_taken, ex_is_load,
           ex_wsel, id_rs, id_rt, id_uses_rt,
    output pc_en, redir_hold, fd_en, de_en, em_en, mw_en,
           fd_flush, de_flush, em_flush, mw_flush, halted
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
// Define HAZARD_PERF_CNT_EN to build the saturating performance counters.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_istall,
  output logic [CNT_W-1:0] cnt_dstall,
  output logic [CNT_W-1:0] cnt_lustall,
  output logic [CNT_W-1:0] cnt_flush
`endif
);

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
    $error("hazard_ctrl: DRAIN_CYCLES must be 1..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_ctrl: CNT_W must be positive");
  end

  typedef enum logic [2:0] {RUN, LU_STALL, DWAIT, REDIR, DRAIN, HALT} state_t;

  state_t     state, state_nxt;
  logic [3:0] drain_cnt;
  logic       halted;
  logic       load_use;
  logic       pc_en, redir_hold;
  logic       fd_en, de_en, em_en, mw_en;
  logic       fd_flush, de_flush, em_flush, mw_flush;

  // Only a load still in EX needs a stall; later loads are forwarded.
  assign load_use = hz.ex_is_load && (hz.ex_wsel != 5'd0) &&
                    ((hz.ex_wsel == hz.id_rs) ||
                     (hz.id_uses_rt && (hz.ex_wsel == hz.id_rt)));

  // Enables/flushes react to same-cycle hits, so they are decoded combinationally.
  always_comb begin
    state_nxt  = state;
    pc_en      = 1'b1;
    redir_hold = 1'b0;
    fd_en      = 1'b1;
    de_en      = 1'b1;
    em_en      = 1'b1;
    mw_en      = 1'b1;
    fd_flush   = 1'b0;
    de_flush   = 1'b0;
    em_flush   = 1'b0;
    mw_flush   = 1'b0;
    case (state)
      RUN, LU_STALL: begin
        state_nxt = RUN;
        if (hz.halt_mem) begin
          pc_en     = 1'b0;
          fd_flush  = 1'b1;
          de_flush  = 1'b1;
          em_flush  = 1'b1;
          state_nxt = DRAIN;
        end else if (hz.dmem_req && !hz.dhit) begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          de_en     = 1'b0;
          em_en     = 1'b0;
          mw_flush  = 1'b1;
          state_nxt = DWAIT;
        end else if (hz.branch_taken) begin
          fd_flush = 1'b1;
          de_flush = 1'b1;
          em_flush = 1'b1;
          if (!hz.ihit) begin
            pc_en      = 1'b0;
            redir_hold = 1'b1;
            state_nxt  = REDIR;
          end
        end else if ((state == RUN) && load_use) begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          de_flush  = 1'b1;
          state_nxt = LU_STALL;
        end else if (!hz.ihit) begin
          pc_en    = 1'b0;
          fd_flush = 1'b1;
        end
      end
      DWAIT: begin
        if (!hz.dhit) begin
          pc_en    = 1'b0;
          fd_en    = 1'b0;
          de_en    = 1'b0;
          em_en    = 1'b0;
          mw_flush = 1'b1;
        end else begin
          pc_en     = hz.ihit;
          fd_flush  = !hz.ihit;
          state_nxt = RUN;
        end
      end
      REDIR: begin
        // On the ihit cycle the fetched target instruction is kept in decode.
        pc_en      = hz.ihit;
        redir_hold = !hz.ihit;
        fd_flush   = !hz.ihit;
        if (hz.ihit) state_nxt = RUN;
      end
      DRAIN: begin
        pc_en    = 1'b0;
        fd_flush = 1'b1;
        de_flush = 1'b1;
        em_flush = 1'b1;
        if (drain_cnt == 4'd0) state_nxt = HALT;
      end
      HALT: begin
        pc_en = 1'b0;
        fd_en = 1'b0;
        de_en = 1'b0;
        em_en = 1'b0;
        mw_en = 1'b0;
      end
      default: state_nxt = RUN;
    endcase
    if (RST) begin
      pc_en      = 1'b0;
      redir_hold = 1'b0;
      fd_en      = 1'b0;
      de_en      = 1'b0;
      em_en      = 1'b0;
      mw_en      = 1'b0;
      fd_flush   = 1'b1;
      de_flush   = 1'b1;
      em_flush   = 1'b1;
      mw_flush   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      drain_cnt <= 4'd0;
      halted    <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state_nxt == DRAIN) && (state != DRAIN))
        drain_cnt <= 4'(DRAIN_CYCLES - 1);
      else if ((state == DRAIN) && (drain_cnt != 4'd0))
        drain_cnt <= drain_cnt - 4'd1;
      if (state_nxt == HALT) halted <= 1'b1;
    end
  end

  assign hz.pc_en      = pc_en;
  assign hz.redir_hold = redir_hold;
  assign hz.fd_en      = fd_en;
  assign hz.de_en      = de_en;
  assign hz.em_en      = em_en;
  assign hz.mw_en      = mw_en;
  assign hz.fd_flush   = fd_flush;
  assign hz.de_flush   = de_flush;
  assign hz.em_flush   = em_flush;
  assign hz.mw_flush   = mw_flush;
  assign hz.halted     = halted;

`ifdef HAZARD_PERF_CNT_EN
  logic ev_istall, ev_dstall, ev_lustall, ev_flush;

  assign ev_istall  = ((state == RUN) || (state == REDIR)) && !hz.ihit;
  assign ev_dstall  = (state == DWAIT) && !hz.dhit;
  assign ev_lustall = (state == LU_STALL);
  assign ev_flush   = ((state == RUN) || (state == LU_STALL)) && !hz.halt_mem &&
                      !(hz.dmem_req && !hz.dhit) && hz.branch_taken;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic ev);
    return (ev && !(&c)) ? c + CNT_W'(1) : c;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_istall  <= '0;
      cnt_dstall  <= '0;
      cnt_lustall <= '0;
      cnt_flush   <= '0;
    end else if (state != HALT) begin
      cnt_istall  <= sat_inc(cnt_istall, ev_istall);
      cnt_dstall  <= sat_inc(cnt_dstall, ev_dstall);
      cnt_lustall <= sat_inc(cnt_lustall, ev_lustall);
      cnt_flush   <= sat_inc(cnt_flush, ev_flush);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl, checked every cycle against a
// flag/countdown model of the sequencing rules.
module tb_hazard_ctrl;
  localparam int DRAIN_CYCLES = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  hazard_ctrl_if hif();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] cnt_istall, cnt_dstall, cnt_lustall, cnt_flush;
  int          m_ci = 0, m_cd = 0, m_cl = 0, m_cf = 0;
`endif

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (hif)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .cnt_istall  (cnt_istall),
    .cnt_dstall  (cnt_dstall),
    .cnt_lustall (cnt_lustall),
    .cnt_flush   (cnt_flush)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending-condition flags instead of a state variable.
  bit m_halt = 0, m_dwait = 0, m_redir = 0, m_lu = 0;
  int m_drain = 0;

  always @(negedge CLK) begin
    logic       pc, rh, lu, runlike;
    logic [3:0] en, fl;  // {fd, de, em, mw}
    bit         prev_lu;
    pc = 1'b1; rh = 1'b0; en = 4'b1111; fl = 4'b0000;
    lu = hif.ex_is_load && (hif.ex_wsel != 0) &&
         ((hif.ex_wsel == hif.id_rs) || (hif.id_uses_rt && (hif.ex_wsel == hif.id_rt)));
    runlike = !RST && !m_halt && (m_drain == 0) && !m_dwait && !m_redir;
    if (RST) begin
      pc = 1'b0; en = 4'b0000; fl = 4'b1111;
    end else if (m_halt) begin
      pc = 1'b0; en = 4'b0000;
    end else if (m_drain > 0) begin
      pc = 1'b0; fl = 4'b1110;
    end else if (m_dwait) begin
      if (!hif.dhit) begin pc = 1'b0; en = 4'b0001; fl = 4'b0001; end
      else begin pc = hif.ihit; fl[3] = !hif.ihit; end
    end else if (m_redir) begin
      pc = hif.ihit; rh = !hif.ihit; fl[3] = !hif.ihit;
    end else if (hif.halt_mem) begin
      pc = 1'b0; fl = 4'b1110;
    end else if (hif.dmem_req && !hif.dhit) begin
      pc = 1'b0; en = 4'b0001; fl = 4'b0001;
    end else if (hif.branch_taken) begin
      fl = 4'b1110; pc = hif.ihit; rh = !hif.ihit;
    end else if (lu && !m_lu) begin
      pc = 1'b0; en[3] = 1'b0; fl[2] = 1'b1;
    end else if (!hif.ihit) begin
      pc = 1'b0; fl[3] = 1'b1;
    end
    chk("outputs", 32'({hif.pc_en, hif.redir_hold, hif.fd_en, hif.de_en, hif.em_en, hif.mw_en,
                        hif.fd_flush, hif.de_flush, hif.em_flush, hif.mw_flush, hif.halted}),
                   32'({pc, rh, en, fl, m_halt}));
`ifdef HAZARD_PERF_CNT_EN
    chk("cnt_istall", cnt_istall, m_ci);
    chk("cnt_dstall", cnt_dstall, m_cd);
    chk("cnt_lustall", cnt_lustall, m_cl);
    chk("cnt_flush", cnt_flush, m_cf);
    if (RST) begin
      m_ci = 0; m_cd = 0; m_cl = 0; m_cf = 0;
    end else begin
      if (((runlike && !m_lu) || (m_redir && m_drain == 0 && !m_halt)) && !hif.ihit) m_ci++;
      if (m_dwait && !hif.dhit) m_cd++;
      if (runlike && m_lu) m_cl++;
      if (runlike && !hif.halt_mem && !(hif.dmem_req && !hif.dhit) && hif.branch_taken) m_cf++;
    end
`endif
    // Advance the model to the next edge.
    if (RST) begin
      m_halt = 0; m_drain = 0; m_dwait = 0; m_redir = 0; m_lu = 0;
    end else if (m_halt) begin
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) m_halt = 1;
    end else if (m_dwait) begin
      m_dwait = !hif.dhit;
    end else if (m_redir) begin
      m_redir = !hif.ihit;
    end else begin
      prev_lu = m_lu;
      m_lu = 0;
      if (hif.halt_mem) m_drain = DRAIN_CYCLES;
      else if (hif.dmem_req && !hif.dhit) m_dwait = 1;
      else if (hif.branch_taken) m_redir = !hif.ihit;
      else if (lu && !prev_lu) m_lu = 1;
    end
  end

  // Apply one cycle of inputs just after the edge; return just after the checking edge.
  task automatic drive(input bit rst, input bit ih, input bit dh, input bit dm, input bit hm,
                       input bit bt, input bit ld, input logic [4:0] ws, input logic [4:0] rs,
                       input logic [4:0] rt, input bit ur);
    @(posedge CLK); #1;
    RST = rst;
    hif.ihit = ih; hif.dhit = dh; hif.dmem_req = dm; hif.halt_mem = hm;
    hif.branch_taken = bt; hif.ex_is_load = ld;
    hif.ex_wsel = ws; hif.id_rs = rs; hif.id_rt = rt; hif.id_uses_rt = ur;
    @(negedge CLK); #1;
  endtask

  task automatic idle();
    drive(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  initial begin
    hif.ihit = 1'b1; hif.dhit = 1'b1; hif.dmem_req = 1'b0; hif.halt_mem = 1'b0;
    hif.branch_taken = 1'b0; hif.ex_is_load = 1'b0;
    hif.ex_wsel = '0; hif.id_rs = '0; hif.id_rt = '0; hif.id_uses_rt = 1'b0;

    // Reset outputs
    drive(1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    chk("rst_pc_en", hif.pc_en, 0);
    chk("rst_en", {hif.fd_en, hif.de_en, hif.em_en, hif.mw_en}, 4'b0000);
    chk("rst_flush", {hif.fd_flush, hif.de_flush, hif.em_flush, hif.mw_flush}, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("idle_pc_en", hif.pc_en, 1);
      chk("idle_halted", hif.halted, 0);
    end

    // Load-use on rs: one stall cycle, not re-evaluated in the following cycle
    drive(0, 1, 1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0);
    chk("lu_stall", {hif.pc_en, hif.fd_en, hif.de_flush}, 3'b001);
    drive(0, 1, 1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0);
    chk("lu_once", {hif.pc_en, hif.fd_en, hif.de_flush}, 3'b110);
    drive(0, 1, 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
    chk("lu_r0", hif.pc_en, 1);
    drive(0, 1, 1, 0, 0, 0, 1, 5'd5, 5'd3, 5'd5, 1);
    chk("lu_rt", hif.pc_en, 0);
    idle();
    drive(0, 1, 1, 0, 0, 0, 1, 5'd5, 5'd3, 5'd5, 0);
    chk("lu_rt_unused", hif.pc_en, 1);

    // D-cache miss for 3 cycles
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      chk("dmiss_stall", {hif.pc_en, hif.em_en, hif.mw_flush}, 3'b001);
    end
    drive(0, 1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    chk("dmiss_resume", {hif.pc_en, hif.em_en, hif.mw_flush}, 3'b110);
    idle();

    // Taken branch with two i-miss cycles
    drive(0, 0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    chk("br_flush", {hif.fd_flush, hif.de_flush, hif.em_flush, hif.redir_hold, hif.pc_en}, 5'b11110);
    drive(0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    chk("redir_wait", {hif.redir_hold, hif.pc_en, hif.de_flush}, 3'b100);
    drive(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    chk("redir_exit", {hif.redir_hold, hif.pc_en}, 2'b01);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end

    // Halt drain, then reset out of HALT
    drive(1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle();
    drive(0, 1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    chk("halt_entry", {hif.pc_en, hif.mw_en, hif.halted}, 3'b010);
    idle();
    chk("drain1", {hif.pc_en, hif.fd_flush, hif.halted}, 3'b010);
    idle();
    chk("drain2", {hif.pc_en, hif.fd_flush, hif.halted}, 3'b010);
    idle();
    chk("halted", {hif.halted, hif.pc_en, hif.mw_en}, 3'b100);
    idle();
    chk("halted_sticky", hif.halted, 1);
    drive(1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle();
    chk("halt_cleared", {hif.halted, hif.pc_en}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
